// File: rtl/data_bus_responder.sv
// Data-memory port responder: a word RAM plus a memory-mapped I/O block holding
// a free-running cycle counter, a compare/match flag and a valid/ready debug FIFO.
module data_bus_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_WORDS  = 256,
    parameter int DBG_DEPTH  = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ADDR_WIDTH-1:0] i_MemAddr,
    input  logic                  i_MemWrEnable,
    input  logic [DATA_WIDTH-1:0] i_MemWrData,
    output logic [DATA_WIDTH-1:0] o_MemRdData,
    output logic [DATA_WIDTH-1:0] o_DbgData,
    output logic                  o_DbgValid,
    input  logic                  i_DbgReady
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int DBG_AW = $clog2(DBG_DEPTH);
    localparam int CNT_W  = DBG_AW + 1;

    localparam logic [2:0] REG_CYCLE  = 3'd0;
    localparam logic [2:0] REG_CMP    = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DBG_TX = 3'd3;

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1'b1);
    localparam logic [DBG_AW-1:0]     PTR_ZERO  = {DBG_AW{1'b0}};
    localparam logic [DBG_AW-1:0]     PTR_ONE   = DBG_AW'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DBG_DEPTH);

    logic [DATA_WIDTH-1:0] ram_r [RAM_WORDS];
    logic [DATA_WIDTH-1:0] dbg_mem_r [DBG_DEPTH];
    logic [DATA_WIDTH-1:0] cycle_r;
    logic [DATA_WIDTH-1:0] timer_cmp_r;
    logic                  match_r;
    logic                  overflow_r;
    logic [DBG_AW-1:0]     dbg_rptr_r;
    logic [DBG_AW-1:0]     dbg_wptr_r;
    logic [CNT_W-1:0]      dbg_count_r;

    logic                  io_sel_s;
    logic [RAM_AW-1:0]     ram_idx_s;
    logic [2:0]            reg_idx_s;
    logic                  ram_wr_s;
    logic                  io_wr_s;
    logic                  cmp_wr_s;
    logic                  status_wr_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  push_ok_s;
    logic                  ovf_set_s;
    logic                  ovf_clr_s;
    logic                  match_set_s;
    logic                  match_clr_s;
    logic                  dbg_full_s;
    logic                  dbg_empty_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [DATA_WIDTH-1:0] status_s;
    logic                  unused_s;

    assign io_sel_s    = i_MemAddr[ADDR_WIDTH-1];
    assign ram_idx_s   = i_MemAddr[RAM_AW+1:2];
    assign reg_idx_s   = i_MemAddr[4:2];
    assign unused_s    = ^{i_MemAddr[ADDR_WIDTH-2:RAM_AW+2], i_MemAddr[1:0]};

    assign ram_wr_s    = i_MemWrEnable & ~io_sel_s;
    assign io_wr_s     = i_MemWrEnable & io_sel_s;
    assign cmp_wr_s    = io_wr_s & (reg_idx_s == REG_CMP);
    assign status_wr_s = io_wr_s & (reg_idx_s == REG_STATUS);
    assign push_s      = io_wr_s & (reg_idx_s == REG_DBG_TX);

    assign dbg_full_s  = (dbg_count_r == CNT_FULL);
    assign dbg_empty_s = (dbg_count_r == CNT_ZERO);
    assign pop_s       = ~dbg_empty_s & i_DbgReady;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok_s   = push_s & (~dbg_full_s | pop_s);
    assign ovf_set_s   = push_s & dbg_full_s & ~pop_s;
    assign ovf_clr_s   = status_wr_s & i_MemWrData[3];
    assign match_set_s = (cycle_r == timer_cmp_r);
    assign match_clr_s = status_wr_s & i_MemWrData[0];

    assign status_s    = {{(DATA_WIDTH-4){1'b0}}, overflow_r, dbg_empty_s, dbg_full_s, match_r};
    assign o_DbgValid  = ~dbg_empty_s;

    // FIFO occupancy for the next edge.
    always_comb begin
        count_next_s = dbg_count_r;
        if (push_ok_s && !pop_s) begin
            count_next_s = dbg_count_r + CNT_ONE;
        end else if (pop_s && !push_ok_s) begin
            count_next_s = dbg_count_r - CNT_ONE;
        end else begin
            count_next_s = dbg_count_r;
        end
    end

    // Read-data decode: RAM or I/O register, same cycle as the address.
    always_comb begin
        o_MemRdData = DATA_ZERO;
        if (io_sel_s) begin
            case (reg_idx_s)
                REG_CYCLE:  o_MemRdData = cycle_r;
                REG_CMP:    o_MemRdData = timer_cmp_r;
                REG_STATUS: o_MemRdData = status_s;
                default:    o_MemRdData = DATA_ZERO;
            endcase
        end else begin
            o_MemRdData = ram_r[ram_idx_s];
        end
    end

    // FIFO head presented to the consumer, zero while empty.
    always_comb begin
        o_DbgData = DATA_ZERO;
        if (dbg_empty_s) begin
            o_DbgData = DATA_ZERO;
        end else begin
            o_DbgData = dbg_mem_r[dbg_rptr_r];
        end
    end

    // Storage arrays carry no reset; RAM survives reset and FIFO slots are
    // invalidated by the pointers.
    always_ff @(posedge i_Clock) begin
        if (ram_wr_s) begin
            ram_r[ram_idx_s] <= i_MemWrData;
        end
        if (push_ok_s) begin
            dbg_mem_r[dbg_wptr_r] <= i_MemWrData;
        end
    end

    // I/O register state; set beats W1C clear for the sticky flags.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cycle_r     <= DATA_ZERO;
            timer_cmp_r <= DATA_ONES;
            match_r     <= 1'b0;
            overflow_r  <= 1'b0;
            dbg_rptr_r  <= PTR_ZERO;
            dbg_wptr_r  <= PTR_ZERO;
            dbg_count_r <= CNT_ZERO;
        end else begin
            cycle_r <= cycle_r + DATA_ONE;
            if (cmp_wr_s) begin
                timer_cmp_r <= i_MemWrData;
            end
            if (match_set_s) begin
                match_r <= 1'b1;
            end else if (match_clr_s) begin
                match_r <= 1'b0;
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
            if (push_ok_s) begin
                dbg_wptr_r <= dbg_wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                dbg_rptr_r <= dbg_rptr_r + PTR_ONE;
            end
            dbg_count_r <= count_next_s;
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed vector table followed by random traffic
// checked against a queue-based reference model.
module tb_data_bus_responder;
    localparam logic [31:0] A_CYC = 32'h8000_0000;
    localparam logic [31:0] A_CMP = 32'h8000_0004;
    localparam logic [31:0] A_ST  = 32'h8000_0008;
    localparam logic [31:0] A_TX  = 32'h8000_000C;
    localparam logic [31:0] DBEEF = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'h0;
    logic        rdy = 1'b0;
    logic [31:0] rd_data;
    logic [31:0] dbg_data;
    logic        dbg_valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_dbg;
    } vec_t;
    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    bit          m_match;
    bit          m_ovf;
    logic [31:0] m_q[$];
    logic [31:0] m_ram[256];
    bit          m_known[256];

    always #5 clk = ~clk;

    data_bus_responder dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_MemAddr    (addr),
        .i_MemWrEnable(we),
        .i_MemWrData  (wd),
        .o_MemRdData  (rd_data),
        .o_DbgData    (dbg_data),
        .o_DbgValid   (dbg_valid),
        .i_DbgReady   (rdy)
    );

    task automatic add(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic y, input logic c, input logic [31:0] e, input logic v,
                       input logic [31:0] h);
        vec_t t;
        t.rst = r; t.addr = a; t.we = w; t.wd = d; t.rdy = y;
        t.chk_rd = c; t.exp_rd = e; t.exp_valid = v; t.exp_dbg = h;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic y);
        @(negedge clk);
        rst = r; addr = a; we = w; wd = d; rdy = y;
        #1;
    endtask

    function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
        logic [2:0] idx;
        logic [7:0] w;
        idx = a[4:2];
        w = a[9:2];
        v = 32'h0;
        if (a[31]) begin
            case (idx)
                3'd0: v = m_cycle;
                3'd1: v = m_cmp;
                3'd2: v = {28'h0, m_ovf, m_q.size() == 0, m_q.size() == 4, m_match};
                default: v = 32'h0;
            endcase
            return 1'b1;
        end
        v = m_ram[w];
        return m_known[w];
    endfunction

    // Advance the model across one rising edge using the inputs held during it.
    task automatic tick();
        bit hit, pop, push, full, st_wr;
        logic [2:0] idx;
        @(posedge clk);
        if (rst) begin
            m_cycle = 32'h0;
            m_cmp = 32'hFFFF_FFFF;
            m_match = 1'b0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            idx = addr[4:2];
            hit = (m_cycle == m_cmp);
            pop = (m_q.size() > 0) && rdy;
            push = we && addr[31] && (idx == 3'd3);
            full = (m_q.size() == 4);
            st_wr = we && addr[31] && (idx == 3'd2);
            if (we && !addr[31]) begin
                m_ram[addr[9:2]] = wd;
                m_known[addr[9:2]] = 1'b1;
            end
            if (we && addr[31] && idx == 3'd1) m_cmp = wd;
            if (hit) m_match = 1'b1;
            else if (st_wr && wd[0]) m_match = 1'b0;
            if (push && full && !pop) m_ovf = 1'b1;
            else if (st_wr && wd[3]) m_ovf = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (push && (!full || pop)) m_q.push_back(wd);
            m_cycle = m_cycle + 32'h1;
        end
    endtask

    initial begin
        logic [31:0] exp_v;
        bit          known;
        logic        r, w, y, io;
        logic [31:0] a, d;
        logic [2:0]  idx;

        // Reset, then CYCLE, TIMER_CMP and RAM behaviour (record index-1 = cycle number)
        add(1'b1, A_CYC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd1, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, A_CMP, 1'b1, 32'd20, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        add(1'b0, A_CMP, 1'b0, 32'h0, 1'b0, 1'b1, 32'd20, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd5, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b1, 32'h1234, 1'b0, 1'b1, 32'd6, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd7, 1'b0, 32'h0);
        add(1'b0, 32'h10, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b0, 32'h10, 1'b1, DBEEF, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0);
        add(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);
        add(1'b0, 32'h410, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);
        add(1'b0, 32'h13, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);
        for (int c = 13; c <= 18; c++) add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'(c), 1'b0, 32'h0);
        // Match at cycle 20, visible from 21; W1C; set-beats-clear at cycle 27
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b1, 32'h1, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, A_CMP, 1'b1, 32'd27, 1'b0, 1'b1, 32'd20, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd26, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b1, 32'h1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b1, 32'h1, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        // FIFO fill with ready low, overflow, then drain
        add(1'b0, A_TX, 1'b1, 32'hA0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        add(1'b0, A_TX, 1'b1, 32'hA1, 1'b0, 1'b1, 32'h0, 1'b1, 32'hA0);
        add(1'b0, A_TX, 1'b1, 32'hA2, 1'b0, 1'b1, 32'h0, 1'b1, 32'hA0);
        add(1'b0, A_TX, 1'b1, 32'hA3, 1'b0, 1'b1, 32'h0, 1'b1, 32'hA0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2, 1'b1, 32'hA0);
        add(1'b0, A_TX, 1'b1, 32'hA4, 1'b0, 1'b1, 32'h0, 1'b1, 32'hA0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA, 1'b1, 32'hA0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA, 1'b1, 32'hA0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'hA1);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'hA2);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'hA3);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0);
        add(1'b0, A_ST, 1'b1, 32'h8, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        // Full FIFO with simultaneous push and pop
        add(1'b0, A_TX, 1'b1, 32'hC0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        add(1'b0, A_TX, 1'b1, 32'hC1, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC0);
        add(1'b0, A_TX, 1'b1, 32'hC2, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC0);
        add(1'b0, A_TX, 1'b1, 32'hC3, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC0);
        add(1'b0, A_TX, 1'b1, 32'hB0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hC0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2, 1'b1, 32'hC1);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2, 1'b1, 32'hC1);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hC2);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hC3);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hB0);
        add(1'b0, A_ST, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
        // Three entries and MATCH set, then reset mid-operation
        add(1'b0, A_CMP, 1'b1, 32'd58, 1'b0, 1'b1, 32'd27, 1'b0, 32'h0);
        add(1'b0, A_TX,  1'b1, 32'hD0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        add(1'b0, A_TX,  1'b1, 32'hD1, 1'b0, 1'b1, 32'h0, 1'b1, 32'hD0);
        add(1'b0, A_TX,  1'b1, 32'hD2, 1'b0, 1'b1, 32'h0, 1'b1, 32'hD0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1, 32'hD0);
        add(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);
        add(1'b0, A_CYC, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h0);
        add(1'b0, A_ST,  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        add(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);
        add(1'b0, 32'h410, 1'b0, 32'h0, 1'b0, 1'b1, DBEEF, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].rdy);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            if (!vecs[i].rst) begin
                check($sformatf("vec%0d_valid", i), {31'h0, dbg_valid}, {31'h0, vecs[i].exp_valid});
                check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
            end
            tick();
        end

        // Random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) == 0);
            y = 1'($urandom_range(0, 1));
            io = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            if (io) a = {1'b1, 26'($urandom), idx, 2'($urandom)};
            else    a = {1'b0, 21'($urandom), 4'b0000, 4'($urandom_range(0, 15)), 2'($urandom)};
            w = !r && ($urandom_range(0, 2) == 0);
            if (io && idx == 3'd1) d = m_cycle + 32'($urandom_range(2, 12));
            else d = $urandom;
            drive(r, a, w, d, y);
            known = model_rd(a, exp_v);
            if (known) check($sformatf("rand%0d_rd", n), rd_data, exp_v);
            if (!r || n > 0) begin
                check($sformatf("rand%0d_valid", n), {31'h0, dbg_valid}, {31'h0, m_q.size() != 0});
                check($sformatf("rand%0d_dbg", n), dbg_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
